if_id_hazard_ctrl: RTL and testbench

- Pipeline control for the IF/ID pipeline register and the PC of the RV32I core.
- Decides each cycle whether the PC and IF/ID advance, hold or flush, and whether a bubble goes into ID/EX.
- Handles load-use stalls, taken-branch/jump redirects and instruction-memory wait states, including a redirect that arrives during a wait.
- Keeps saturating stall/flush event counters and a sticky fetch-timeout error.

---
 rtl/if_id_hazard_ctrl_if.sv | 15 +
 rtl/if_id_hazard_ctrl.sv | 46 ++++
 tb/tb_if_id_hazard_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_id_hazard_ctrl_if.sv
// if_id_hazard_ctrl_if: signal bundle between the IF/ID datapath (master) and its hazard controller (slave)
interface if_id_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic uses_rs1, uses_rs2, id_ex_mem_read, branch_taken, imem_ready;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, fetch_err;
  logic [CNT_W-1:0] stall_count, flush_count;
  modport master (
    output if_id_rs1, if_id_rs2, id_ex_rd, uses_rs1, uses_rs2, id_ex_mem_read, branch_taken, imem_ready,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, fetch_err, stall_count, flush_count
  );
  modport slave (
    input  if_id_rs1, if_id_rs2, id_ex_rd, uses_rs1, uses_rs2, id_ex_mem_read, branch_taken, imem_ready,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, fetch_err, stall_count, flush_count
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl: PC/IF-ID advance, hold and flush control with load-use, redirect and imem-wait handling
module if_id_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  if_id_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, WAIT} state_t;
  localparam logic [9:0] TMO = 10'(TIMEOUT);
  state_t state, state_n;
  logic pend, pend_n, load_use;
  logic [9:0] wcnt, wcnt_n;
  assign load_use = bus.id_ex_mem_read && bus.id_ex_rd != 5'd0 &&
                    ((bus.uses_rs1 && bus.if_id_rs1 == bus.id_ex_rd) ||
                     (bus.uses_rs2 && bus.if_id_rs2 == bus.id_ex_rd));
  // {pc_we, if_id_we, if_id_flush, id_ex_flush}; a pending redirect discards the stale word on the first ready cycle
  assign {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush} =
    bus.branch_taken ? 4'b1011 :
    !bus.imem_ready  ? 4'b0001 :
    pend             ? 4'b1011 :
    load_use         ? 4'b0001 : 4'b1100;
  always_comb begin
    state_n = bus.imem_ready ? RUN : WAIT;
    wcnt_n  = bus.imem_ready ? 10'd0 : state == RUN ? 10'd1 : wcnt == TMO ? wcnt : wcnt + 10'd1;
    pend_n  = !bus.imem_ready && (pend || bus.branch_taken);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      wcnt            <= '0;
      pend            <= 1'b0;
      bus.fetch_err   <= 1'b0;
      bus.stall_count <= '0;
      bus.flush_count <= '0;
    end else begin
      state         <= state_n;
      wcnt          <= wcnt_n;
      pend          <= pend_n;
      bus.fetch_err <= bus.fetch_err || wcnt_n == TMO;
      if (!bus.pc_we && !(&bus.stall_count)) bus.stall_count <= bus.stall_count + CNT_W'(1);
      if (bus.branch_taken && !(&bus.flush_count)) bus.flush_count <= bus.flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb_if_id_hazard_ctrl: two parameterisations driven in parallel, checked every cycle against a behavioural model
module tb_if_id_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, br, rdy;
  int errors = 0;
  int checks = 0;
  int m_st = 0, m_fl = 0, m_low = 0, m_max = 0;
  bit m_pend = 1'b0;

  if_id_hazard_ctrl_if #(.CNT_W(16)) bus_a();
  if_id_hazard_ctrl_if #(.CNT_W(4))  bus_b();
  assign {bus_a.if_id_rs1, bus_a.if_id_rs2, bus_a.id_ex_rd, bus_a.uses_rs1, bus_a.uses_rs2,
          bus_a.id_ex_mem_read, bus_a.branch_taken, bus_a.imem_ready} = {rs1, rs2, rd, u1, u2, mr, br, rdy};
  assign {bus_b.if_id_rs1, bus_b.if_id_rs2, bus_b.id_ex_rd, bus_b.uses_rs1, bus_b.uses_rs2,
          bus_b.id_ex_mem_read, bus_b.branch_taken, bus_b.imem_ready} = {rs1, rs2, rd, u1, u2, mr, br, rdy};

  if_id_hazard_ctrl #(.CNT_W(16), .TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  if_id_hazard_ctrl #(.CNT_W(4),  .TIMEOUT(4))   dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  // model: event counts and the longest imem_ready-low run since reset
  always @(negedge clk) begin
    bit p, lu, e_pc, e_we, e_iff, e_idf;
    int st, fl, lo, mx;
    p  = rst ? 1'b0 : m_pend;
    st = rst ? 0 : m_st;
    fl = rst ? 0 : m_fl;
    lo = rst ? 0 : m_low;
    mx = rst ? 0 : m_max;
    lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e_pc  = br || (rdy && (p || !lu));
    e_we  = !br && rdy && !p && !lu;
    e_iff = br || (rdy && p);
    e_idf = !e_we;
    chk("ctl_a", {bus_a.pc_we, bus_a.if_id_we, bus_a.if_id_flush, bus_a.id_ex_flush}, {e_pc, e_we, e_iff, e_idf});
    chk("ctl_b", {bus_b.pc_we, bus_b.if_id_we, bus_b.if_id_flush, bus_b.id_ex_flush}, {e_pc, e_we, e_iff, e_idf});
    chk("stall_a", bus_a.stall_count, sat(st, 16));
    chk("stall_b", bus_b.stall_count, sat(st, 4));
    chk("flush_a", bus_a.flush_count, sat(fl, 16));
    chk("flush_b", bus_b.flush_count, sat(fl, 4));
    chk("err_a", bus_a.fetch_err, mx >= 255);
    chk("err_b", bus_b.fetch_err, mx >= 4);
    if (!rst) begin
      lo = rdy ? 0 : lo + 1;
      m_st   <= st + (e_pc ? 0 : 1);
      m_fl   <= fl + (br ? 1 : 0);
      m_pend <= !rdy && (p || br);
      m_low  <= lo;
      m_max  <= lo > mx ? lo : mx;
    end else begin
      m_st <= 0; m_fl <= 0; m_pend <= 1'b0; m_low <= 0; m_max <= 0;
    end
  end

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; rdy = 1;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic at_neg();
    @(negedge clk); #1;
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lowleft;
    idle();
    at_neg();
    chk("rst_pc_we", bus_a.pc_we, 1);
    chk("rst_if_id_we", bus_a.if_id_we, 1);
    chk("rst_counts", {bus_a.stall_count, bus_a.flush_count}, 0);
    chk("rst_err", bus_a.fetch_err, 0);
    tick();
    rst = 1'b0;
    mr = 1; rd = 5; rs1 = 5; u1 = 1;
    at_neg();
    chk("lu_ctl", {bus_a.pc_we, bus_a.if_id_we, bus_a.id_ex_flush}, 3'b001);
    tick();
    idle();
    at_neg();
    chk("lu_stall_count", bus_a.stall_count, 1);
    chk("lu_released", bus_a.pc_we, 1);
    mr = 1; u1 = 1;
    at_neg();
    chk("lu_rd0", {bus_a.pc_we, bus_a.if_id_we}, 2'b11);
    tick();
    mr = 1; rd = 5; rs1 = 5; u1 = 1; br = 1;
    at_neg();
    chk("br_lu_ctl", {bus_a.pc_we, bus_a.if_id_flush, bus_a.id_ex_flush}, 3'b111);
    tick();
    idle();
    at_neg();
    chk("br_lu_flush", bus_a.flush_count, 1);
    chk("br_lu_stall", bus_a.stall_count, 1);
    tick();
    do_reset();
    rdy = 0;
    tick();
    br = 1;
    tick();
    br = 0;
    tick();
    rdy = 1;
    at_neg();
    chk("pend_done_ctl", {bus_a.pc_we, bus_a.if_id_we, bus_a.if_id_flush}, 3'b101);
    tick();
    at_neg();
    chk("pend_flush", bus_a.flush_count, 1);
    chk("pend_stall", bus_a.stall_count, 2);
    chk("pend_cleared", {bus_a.pc_we, bus_a.if_id_flush}, 2'b10);
    tick();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      rdy = 0;
      at_neg();
      chk("tmo_err_b", bus_b.fetch_err, (i - 1) >= 4);
      tick();
    end
    rdy = 1;
    at_neg();
    chk("tmo_err_b6", bus_b.fetch_err, 1);
    chk("tmo_err_a6", bus_a.fetch_err, 0);
    tick();
    at_neg();
    chk("tmo_sticky", bus_b.fetch_err, 1);
    tick();
    rdy = 0; br = 1;
    tick();
    br = 0;
    repeat (49) tick();
    do_reset();
    at_neg();
    chk("midwait_ctl", {bus_a.pc_we, bus_a.if_id_we, bus_a.if_id_flush}, 3'b110);
    chk("midwait_counts", {bus_a.stall_count, bus_a.flush_count}, 0);
    chk("midwait_err", {bus_a.fetch_err, bus_b.fetch_err}, 0);
    tick();
    rdy = 0;
    repeat (20) tick();
    rdy = 1;
    at_neg();
    chk("sat_stall_b", bus_b.stall_count, 15);
    chk("sat_stall_a", bus_a.stall_count, 20);
    tick();
    rdy = 0;
    repeat (260) tick();
    rdy = 1;
    at_neg();
    chk("tmo_err_a", bus_a.fetch_err, 1);
    tick();
    lowleft = 0;
    repeat (3000) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      mr  = $urandom_range(0, 9) < 3;
      br  = $urandom_range(0, 99) < 12;
      if (lowleft == 0 && $urandom_range(0, 9) == 0)
        lowleft = $urandom_range(0, 299) == 0 ? $urandom_range(250, 300) : $urandom_range(1, 8);
      rdy = lowleft == 0;
      if (lowleft > 0) lowleft--;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        lowleft = 0;
      end else tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
